tablero_cartas: RTL and testbench



---
 rtl/memoria_pkg.sv | 43 ++++
 rtl/tablero_cartas_if.sv | 33 +++
 rtl/lfsr16.sv | 24 ++
 rtl/tablero_cartas.sv | 221 ++++++++++++++++++++++
 tb/tb_tablero_cartas.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/memoria_pkg.sv
// Shared definitions for the memory game: FSM state codes, board geometry,
// LFSR polynomial and the power-on card layout.
package memoria_pkg;

  localparam int unsigned N_CARTAS = 16;
  localparam int unsigned SYM_W    = 3;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned LFSR_W   = 16;

  // x^16 + x^14 + x^13 + x^11, Fibonacci form: feedback from bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [STATE_W-1:0] {
    INICIO          = 4'd0,
    MUESTRO_CORTAS  = 4'd1,
    OCULTA_CORTAS   = 4'd2,
    REVUELVE_CORTAS = 4'd3,
    ESTADO_4        = 4'd4,
    TURNO_JUGADOR   = 4'd5,
    UNA_CARTA       = 4'd6,
    DOS_CARTAS      = 4'd7,
    MOSTRAR_RANDOM  = 4'd8,
    ESTADO_9        = 4'd9,
    CONCLUSION      = 4'd10
  } state_t;

  typedef logic [N_CARTAS-1:0][SYM_W-1:0] board_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  // Sorted layout: card i holds symbol i>>1, so pairs sit side by side
  function automatic board_t board_reset();
    board_t b;
    for (int k = 0; k < N_CARTAS; k++) begin
      b[k] = SYM_W'(k >> 1);
    end
    return b;
  endfunction

endpackage

// File: rtl/tablero_cartas_if.sv
// Link between the game FSM (master) and the card board (slave).
interface tablero_cartas_if;
  import memoria_pkg::*;

  logic [STATE_W-1:0]        state;
  logic                      sel_valid;
  logic [IDX_W-1:0]          sel_idx;
  logic                      cartas_mostradas;
  logic                      cartas_ocultas;
  logic                      cartas_revueltas;
  logic                      carta_randomizada;
  logic                      se_eligio_carta;
  logic                      cartas_verificadas;
  logic                      hubo_pareja;
  logic [N_CARTAS*SYM_W-1:0] simbolos;
  logic [N_CARTAS-1:0]       visibles;
  logic [N_CARTAS-1:0]       emparejadas;

  modport master (
    output state, sel_valid, sel_idx,
    input  cartas_mostradas, cartas_ocultas, cartas_revueltas, carta_randomizada,
           se_eligio_carta, cartas_verificadas, hubo_pareja,
           simbolos, visibles, emparejadas
  );

  modport slave (
    input  state, sel_valid, sel_idx,
    output cartas_mostradas, cartas_ocultas, cartas_revueltas, carta_randomizada,
           se_eligio_carta, cartas_verificadas, hubo_pareja,
           simbolos, visibles, emparejadas
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used for shuffling and random picks.
module lfsr16
  import memoria_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [LFSR_W-1:0] o_lfsr
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= i_seed;
    end else if (i_en) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/tablero_cartas.sv
// Card-board datapath for the 16-card memory game: holds symbols, visibility
// and matches, and reports phase completion back to the game FSM.
module tablero_cartas
  import memoria_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 100000000,
  parameter int unsigned MATCH_DELAY = 50000000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
)(
  input logic             clk,
  input logic             rst,
  tablero_cartas_if.slave bus
);

  localparam int unsigned CNT_W = 32;
  localparam int unsigned PRB_W = 5;

  state_t              r_state_q, w_state;
  logic                w_chg;
  logic [LFSR_W-1:0]   w_lfsr;
  logic                w_lfsr_unused;
  logic [IDX_W-1:0]    w_rnd;

  board_t              r_sim, w_sim_d;
  logic [N_CARTAS-1:0] r_vis, w_vis_d, r_emp, w_emp_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic [IDX_W-1:0]    r_i, w_i_d, r_ptr, w_ptr_d;
  logic [IDX_W-1:0]    r_primera, w_primera_d, r_segunda, w_segunda_d;
  logic [PRB_W-1:0]    r_probes, w_probes_d;
  logic [1:0]          r_picks, w_picks_d;
  logic                r_mostradas, w_mostradas_d, r_ocultas, w_ocultas_d;
  logic                r_revueltas, w_revueltas_d, r_randomizada, w_randomizada_d;
  logic                r_eligio, w_eligio_d, r_verif, w_verif_d;
  logic                r_pareja, w_pareja_d, r_cmp_done, w_cmp_done_d;

  lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (1'b1),
    .i_seed (LFSR_SEED),
    .o_lfsr (w_lfsr)
  );

  assign w_rnd         = w_lfsr[IDX_W-1:0];
  assign w_lfsr_unused = ^w_lfsr[LFSR_W-1:IDX_W];
  assign w_state       = state_t'(bus.state);
  assign w_chg         = (w_state != r_state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q     <= INICIO;
      r_sim         <= board_reset();
      r_vis         <= '0;
      r_emp         <= '0;
      r_cnt         <= '0;
      r_i           <= '0;
      r_ptr         <= '0;
      r_primera     <= '0;
      r_segunda     <= '0;
      r_probes      <= '0;
      r_picks       <= '0;
      r_mostradas   <= 1'b0;
      r_ocultas     <= 1'b0;
      r_revueltas   <= 1'b0;
      r_randomizada <= 1'b0;
      r_eligio      <= 1'b0;
      r_verif       <= 1'b0;
      r_pareja      <= 1'b0;
      r_cmp_done    <= 1'b0;
    end else begin
      r_state_q     <= w_state;
      r_sim         <= w_sim_d;
      r_vis         <= w_vis_d;
      r_emp         <= w_emp_d;
      r_cnt         <= w_cnt_d;
      r_i           <= w_i_d;
      r_ptr         <= w_ptr_d;
      r_primera     <= w_primera_d;
      r_segunda     <= w_segunda_d;
      r_probes      <= w_probes_d;
      r_picks       <= w_picks_d;
      r_mostradas   <= w_mostradas_d;
      r_ocultas     <= w_ocultas_d;
      r_revueltas   <= w_revueltas_d;
      r_randomizada <= w_randomizada_d;
      r_eligio      <= w_eligio_d;
      r_verif       <= w_verif_d;
      r_pareja      <= w_pareja_d;
      r_cmp_done    <= w_cmp_done_d;
    end
  end

  always_comb begin
    w_sim_d         = r_sim;
    w_vis_d         = r_vis;
    w_emp_d         = r_emp;
    w_cnt_d         = r_cnt;
    w_i_d           = r_i;
    w_ptr_d         = r_ptr;
    w_primera_d     = r_primera;
    w_segunda_d     = r_segunda;
    w_probes_d      = r_probes;
    w_picks_d       = r_picks;
    w_mostradas_d   = r_mostradas;
    w_ocultas_d     = r_ocultas;
    w_revueltas_d   = r_revueltas;
    w_randomizada_d = r_randomizada;
    w_eligio_d      = 1'b0;
    w_verif_d       = 1'b0;
    w_pareja_d      = r_pareja;
    w_cmp_done_d    = r_cmp_done;

    // A new state code aborts whatever phase was running; the board is kept
    if (w_chg) begin
      w_cnt_d         = '0;
      w_mostradas_d   = 1'b0;
      w_ocultas_d     = 1'b0;
      w_revueltas_d   = 1'b0;
      w_randomizada_d = 1'b0;
      w_cmp_done_d    = 1'b0;
      w_i_d           = IDX_W'(N_CARTAS - 1);
      w_ptr_d         = w_rnd;
      w_probes_d      = '0;
    end

    case (w_state)
      INICIO: begin
        w_vis_d = '0;
        w_emp_d = '0;
      end
      MUESTRO_CORTAS: begin
        w_vis_d = '1;
        if (!w_chg && !r_mostradas) begin
          if (r_cnt == CNT_W'(SHOW_CYCLES - 1)) w_mostradas_d = 1'b1;
          else                                  w_cnt_d       = r_cnt + CNT_W'(1);
        end
      end
      OCULTA_CORTAS: begin
        if (w_chg) w_vis_d     = '0;
        else       w_ocultas_d = 1'b1;
      end
      REVUELVE_CORTAS: begin
        // Fisher-Yates: retry until the random nibble lands in 0..i
        if (!w_chg && !r_revueltas) begin
          if (r_i == '0) begin
            w_revueltas_d = 1'b1;
            w_emp_d       = '0;
          end else if (w_rnd <= r_i) begin
            w_sim_d[r_i]   = r_sim[w_rnd];
            w_sim_d[w_rnd] = r_sim[r_i];
            w_i_d          = r_i - IDX_W'(1);
          end
        end
      end
      TURNO_JUGADOR, UNA_CARTA: begin
        if (bus.sel_valid && !r_vis[bus.sel_idx] && !r_emp[bus.sel_idx] &&
            !r_eligio && (r_picks < 2'd2)) begin
          if (r_picks == 2'd0) w_primera_d = bus.sel_idx;
          else                 w_segunda_d = bus.sel_idx;
          w_vis_d[bus.sel_idx] = 1'b1;
          w_picks_d            = r_picks + 2'd1;
          w_eligio_d           = 1'b1;
        end
      end
      MOSTRAR_RANDOM: begin
        // One probe per cycle from a random start; gives up after a full lap
        if (!w_chg && !r_randomizada) begin
          if ((r_picks == 2'd2) || (r_probes == PRB_W'(N_CARTAS))) begin
            w_randomizada_d = 1'b1;
          end else begin
            if (!r_vis[r_ptr] && !r_emp[r_ptr] &&
                !((r_picks != 2'd0) && (r_primera == r_ptr))) begin
              if (r_picks == 2'd0) w_primera_d = r_ptr;
              else                 w_segunda_d = r_ptr;
              w_vis_d[r_ptr] = 1'b1;
              w_picks_d      = r_picks + 2'd1;
            end
            w_ptr_d    = r_ptr + IDX_W'(1);
            w_probes_d = r_probes + PRB_W'(1);
          end
        end
      end
      DOS_CARTAS: begin
        if (!w_chg && !r_cmp_done) begin
          if (r_cnt == CNT_W'(MATCH_DELAY - 1)) begin
            if (r_sim[r_primera] == r_sim[r_segunda]) begin
              w_emp_d[r_primera] = 1'b1;
              w_emp_d[r_segunda] = 1'b1;
              w_pareja_d         = 1'b1;
            end else begin
              w_vis_d[r_primera] = 1'b0;
              w_vis_d[r_segunda] = 1'b0;
              w_pareja_d         = 1'b0;
            end
            w_verif_d    = 1'b1;
            w_cmp_done_d = 1'b1;
            w_picks_d    = 2'd0;
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
      end
      CONCLUSION: begin
        w_vis_d = '1;
      end
      default: ;
    endcase
  end

  assign bus.simbolos           = r_sim;
  assign bus.visibles           = r_vis;
  assign bus.emparejadas        = r_emp;
  assign bus.cartas_mostradas   = r_mostradas;
  assign bus.cartas_ocultas     = r_ocultas;
  assign bus.cartas_revueltas   = r_revueltas;
  assign bus.carta_randomizada  = r_randomizada;
  assign bus.se_eligio_carta    = r_eligio;
  assign bus.cartas_verificadas = r_verif;
  assign bus.hubo_pareja        = r_pareja;

endmodule

// File: tb/tb_tablero_cartas.sv
// Directed bench for tablero_cartas with short show/match delays.
module tb_tablero_cartas;
  import memoria_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [47:0] exp_reset;
  logic p;

  always #5 clk = ~clk;

  tablero_cartas_if bus();

  tablero_cartas #(
    .SHOW_CYCLES (4),
    .MATCH_DELAY (3),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [6:0] flags();
    return {bus.cartas_mostradas, bus.cartas_ocultas, bus.cartas_revueltas,
            bus.carta_randomizada, bus.se_eligio_carta, bus.cartas_verificadas,
            bus.hubo_pareja};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_pick(input logic [3:0] idx, output logic pulse);
    bus.sel_idx   = idx;
    bus.sel_valid = 1'b1;
    tick();
    pulse         = bus.se_eligio_carta;
    bus.sel_valid = 1'b0;
  endtask

  task automatic apply_reset();
    bus.state = 4'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.state = 4'd0;
    tick();
    total++; if (bus.simbolos !== exp_reset) begin bad++; $display("FAIL reset_sym: got %h want %h", bus.simbolos, exp_reset); end
    total++; if (bus.visibles !== 16'h0000) begin bad++; $display("FAIL reset_vis: got %h want 0000", bus.visibles); end
    total++; if (bus.emparejadas !== 16'h0000) begin bad++; $display("FAIL reset_emp: got %h want 0000", bus.emparejadas); end
    total++; if (flags() !== 7'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000000", flags()); end
    rst = 1'b0;
    tick();
    total++; if (bus.visibles !== 16'h0000) begin bad++; $display("FAIL inicio_vis: got %h want 0000", bus.visibles); end
  endtask

  task automatic test_show_hide();
    bus.state = 4'd1;
    tick();
    total++; if (bus.visibles !== 16'hFFFF) begin bad++; $display("FAIL show_vis: got %h want ffff", bus.visibles); end
    repeat (3) tick();
    total++; if (bus.cartas_mostradas !== 1'b0) begin bad++; $display("FAIL show_early: got %b want 0", bus.cartas_mostradas); end
    tick();
    total++; if (bus.cartas_mostradas !== 1'b1) begin bad++; $display("FAIL show_done: got %b want 1", bus.cartas_mostradas); end
    bus.state = 4'd2;
    tick();
    total++; if (bus.visibles !== 16'h0000) begin bad++; $display("FAIL hide_vis: got %h want 0000", bus.visibles); end
    total++; if ({bus.cartas_mostradas, bus.cartas_ocultas} !== 2'b00) begin bad++; $display("FAIL hide_first: got %b want 00", {bus.cartas_mostradas, bus.cartas_ocultas}); end
    tick();
    total++; if (bus.cartas_ocultas !== 1'b1) begin bad++; $display("FAIL hide_done: got %b want 1", bus.cartas_ocultas); end
  endtask

  task automatic test_shuffle();
    int n = 0;
    logic [47:0] sv;
    bus.state = 4'd3;
    while (bus.cartas_revueltas !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++; if (bus.cartas_revueltas !== 1'b1) begin bad++; $display("FAIL shuffle_timeout: got %b want 1 within 200", bus.cartas_revueltas); end
    sv = bus.simbolos;
    for (int s = 0; s < 8; s++) begin
      int c = 0;
      for (int k = 0; k < 16; k++) if (sv[3*k +: 3] == 3'(s)) c++;
      total++; if (c != 2) begin bad++; $display("FAIL shuffle_count sym %0d: got %0d want 2", s, c); end
    end
    total++; if (sv === exp_reset) begin bad++; $display("FAIL shuffle_order: got %h want anything but %h", sv, exp_reset); end
    total++; if (bus.emparejadas !== 16'h0000) begin bad++; $display("FAIL shuffle_emp: got %h want 0000", bus.emparejadas); end
  endtask

  task automatic test_pick();
    bus.state = 4'd5;
    tick();
    do_pick(4'd3, p);
    total++; if (p !== 1'b1) begin bad++; $display("FAIL pick_pulse: got %b want 1", p); end
    total++; if (bus.visibles !== 16'h0008) begin bad++; $display("FAIL pick_vis: got %h want 0008", bus.visibles); end
    tick();
    total++; if (bus.se_eligio_carta !== 1'b0) begin bad++; $display("FAIL pick_pulse_len: got %b want 0", bus.se_eligio_carta); end
    bus.state = 4'd6;
    tick();
    do_pick(4'd3, p);
    total++; if (p !== 1'b0) begin bad++; $display("FAIL repick_ignored: got %b want 0", p); end
    total++; if (bus.visibles !== 16'h0008) begin bad++; $display("FAIL repick_vis: got %h want 0008", bus.visibles); end
  endtask

  task automatic test_match();
    apply_reset();
    bus.state = 4'd5; tick();
    do_pick(4'd0, p); tick();
    bus.state = 4'd6; tick();
    do_pick(4'd1, p); tick();
    total++; if (bus.visibles !== 16'h0003) begin bad++; $display("FAIL match_picks: got %h want 0003", bus.visibles); end
    bus.state = 4'd7;
    repeat (3) tick();
    total++; if (bus.cartas_verificadas !== 1'b0) begin bad++; $display("FAIL match_early: got %b want 0", bus.cartas_verificadas); end
    tick();
    total++; if (bus.cartas_verificadas !== 1'b1) begin bad++; $display("FAIL match_verif: got %b want 1", bus.cartas_verificadas); end
    total++; if (bus.hubo_pareja !== 1'b1) begin bad++; $display("FAIL match_pareja: got %b want 1", bus.hubo_pareja); end
    total++; if (bus.emparejadas !== 16'h0003) begin bad++; $display("FAIL match_emp: got %h want 0003", bus.emparejadas); end
    tick();
    total++; if ({bus.cartas_verificadas, bus.hubo_pareja} !== 2'b01) begin bad++; $display("FAIL match_after: got %b want 01", {bus.cartas_verificadas, bus.hubo_pareja}); end
  endtask

  task automatic test_nomatch();
    bus.state = 4'd5; tick();
    do_pick(4'd2, p); tick();
    bus.state = 4'd6; tick();
    do_pick(4'd4, p); tick();
    total++; if (bus.visibles !== 16'h0017) begin bad++; $display("FAIL nomatch_picks: got %h want 0017", bus.visibles); end
    bus.state = 4'd7;
    repeat (4) tick();
    total++; if (bus.cartas_verificadas !== 1'b1) begin bad++; $display("FAIL nomatch_verif: got %b want 1", bus.cartas_verificadas); end
    total++; if (bus.hubo_pareja !== 1'b0) begin bad++; $display("FAIL nomatch_pareja: got %b want 0", bus.hubo_pareja); end
    total++; if (bus.visibles !== 16'h0003) begin bad++; $display("FAIL nomatch_vis: got %h want 0003", bus.visibles); end
    total++; if (bus.emparejadas !== 16'h0003) begin bad++; $display("FAIL nomatch_emp: got %h want 0003", bus.emparejadas); end
  endtask

  task automatic test_random();
    int n = 0;
    apply_reset();
    bus.state = 4'd5; tick();
    do_pick(4'd0, p); tick();
    bus.state = 4'd8;
    while (bus.carta_randomizada !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    total++; if (bus.carta_randomizada !== 1'b1) begin bad++; $display("FAIL random_timeout: got %b want 1 within 40", bus.carta_randomizada); end
    total++; if ($countones(bus.visibles) != 2) begin bad++; $display("FAIL random_count: got %h want two bits set", bus.visibles); end
    total++; if (bus.visibles[0] !== 1'b1) begin bad++; $display("FAIL random_keep0: got %b want 1", bus.visibles[0]); end
    total++; if ((bus.visibles & bus.emparejadas) !== 16'h0000) begin bad++; $display("FAIL random_unmatched: got %h want 0000", bus.visibles & bus.emparejadas); end
  endtask

  task automatic test_reset_mid_shuffle();
    bus.state = 4'd3;
    repeat (6) tick();
    rst = 1'b1;
    #2;
    total++; if (bus.simbolos !== exp_reset) begin bad++; $display("FAIL midrst_sym: got %h want %h", bus.simbolos, exp_reset); end
    tick();
    total++; if (bus.visibles !== 16'h0000) begin bad++; $display("FAIL midrst_vis: got %h want 0000", bus.visibles); end
    total++; if (flags() !== 7'b0) begin bad++; $display("FAIL midrst_flags: got %b want 0000000", flags()); end
    total++; if (bus.simbolos !== exp_reset) begin bad++; $display("FAIL midrst_sym_held: got %h want %h", bus.simbolos, exp_reset); end
    rst = 1'b0;
    bus.state = 4'd0;
    tick();
  endtask

  initial begin
    for (int k = 0; k < 16; k++) exp_reset[3*k +: 3] = 3'(k >> 1);
    rst           = 1'b1;
    bus.state     = 4'd0;
    bus.sel_valid = 1'b0;
    bus.sel_idx   = 4'd0;
    test_reset();
    test_show_hide();
    test_shuffle();
    test_pick();
    test_match();
    test_nomatch();
    test_random();
    test_reset_mid_shuffle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
